// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and ALU-side signals around alu_arbiter.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface alu_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IW   = 3
);

  // Requester -> arbiter
  logic [NREQ-1:0]   REQ_VALID;
  logic [8*NREQ-1:0] REQ_A;
  logic [8*NREQ-1:0] REQ_B;
  logic [3*NREQ-1:0] REQ_OP;
  logic [NREQ-1:0]   REQ_READY;

  // Arbiter -> requester responses
  logic [NREQ-1:0]   RSP_VALID;
  logic [NREQ-1:0]   RSP_READY;
  logic [7:0]        RSP_Y;
  logic [3:0]        RSP_FLAGS;

  // Shared external ALU
  logic [7:0]        ALU_A;
  logic [7:0]        ALU_B;
  logic [2:0]        ALU_OP;
  logic [7:0]        ALU_Y;
  logic              ALU_C;
  logic              ALU_V;
  logic              ALU_N;
  logic              ALU_Z;

  // Status
  logic              BUSY;
  logic [IW-1:0]     GRANT_IDX;

  modport slave (
    input  REQ_VALID, REQ_A, REQ_B, REQ_OP, RSP_READY,
    input  ALU_Y, ALU_C, ALU_V, ALU_N, ALU_Z,
    output REQ_READY, RSP_VALID, RSP_Y, RSP_FLAGS,
    output ALU_A, ALU_B, ALU_OP, BUSY, GRANT_IDX
  );

  modport master (
    output REQ_VALID, REQ_A, REQ_B, REQ_OP, RSP_READY,
    output ALU_Y, ALU_C, ALU_V, ALU_N, ALU_Z,
    input  REQ_READY, RSP_VALID, RSP_Y, RSP_FLAGS,
    input  ALU_A, ALU_B, ALU_OP, BUSY, GRANT_IDX
  );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational 8-bit ALU among
// NREQ requesters. A granted request is latched, presented to the ALU for
// one cycle, and the registered result is handed back over valid/ready.
// One operation takes IDLE -> EXEC -> RESP, i.e. at best one per 3 cycles.
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 3
) (
  input  logic         CLK,
  input  logic         RST_N,
  alu_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [7:0]      y_q, y_d;
  logic [3:0]      flags_q, flags_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

  logic            win_found;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic [7:0]      sel_a, sel_b;
  logic [2:0]      sel_op;
  logic [NREQ-1:0] grant_oh;
  logic            rsp_ack;
  logic [IW-1:0]   ptr_inc;

  logic [7:0]      lane_a  [NREQ];
  logic [7:0]      lane_b  [NREQ];
  logic [2:0]      lane_op [NREQ];

  // Unpack the per-requester operand lanes and decode the held grant.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign lane_a[gi]   = bus.REQ_A[8*gi +: 8];
    assign lane_b[gi]   = bus.REQ_B[8*gi +: 8];
    assign lane_op[gi]  = bus.REQ_OP[3*gi +: 3];
    assign grant_oh[gi] = (grant_q == IW'(gi));
  end

  // Round-robin search: first valid at or above the pointer, else first
  // valid below it, which is the same as scanning upward with wrap.
  always_comb begin
    win_found = 1'b0;
    win_oh    = '0;
    win_idx   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!win_found && bus.REQ_VALID[j] && (IW'(j) >= ptr_q)) begin
        win_found = 1'b1;
        win_oh[j] = 1'b1;
        win_idx   = IW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!win_found && bus.REQ_VALID[j] && (IW'(j) < ptr_q)) begin
        win_found = 1'b1;
        win_oh[j] = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  // AND-OR mux of the winner's operands; win_oh is one-hot or zero.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win_oh[j]) begin
        sel_a  = sel_a | lane_a[j];
        sel_b  = sel_b | lane_b[j];
        sel_op = sel_op | lane_op[j];
      end
    end
  end

  // Only the owner's RSP_READY bit matters; rsp_valid_q is one-hot on it.
  assign rsp_ack = |(bus.RSP_READY & rsp_valid_q);
  assign ptr_inc = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);

  // Next-state logic for the IDLE/EXEC/RESP sequence and its datapath.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    y_d         = y_q;
    flags_d     = flags_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_EXEC;
          grant_d = win_idx;
          a_d     = sel_a;
          b_d     = sel_b;
          op_d    = sel_op;
        end
      end
      ST_EXEC: begin
        // The ALU sees the latched operands all cycle; capture at its end.
        y_d         = bus.ALU_Y;
        flags_d     = {bus.ALU_C, bus.ALU_V, bus.ALU_N, bus.ALU_Z};
        rsp_valid_d = grant_oh;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Hold the response indefinitely until its owner takes it.
        if (rsp_ack) begin
          rsp_valid_d = '0;
          ptr_d       = ptr_inc;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      y_q         <= '0;
      flags_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Accept strobe exists only while idle, for the winner only.
  assign bus.REQ_READY = (state_q == ST_IDLE) ? win_oh : '0;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_Y     = y_q;
  assign bus.RSP_FLAGS = flags_q;
  assign bus.ALU_A     = a_q;
  assign bus.ALU_B     = b_q;
  assign bus.ALU_OP    = op_q;
  assign bus.BUSY      = (state_q != ST_IDLE);
  assign bus.GRANT_IDX = grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed table of single operations, hand-written
// multi-cycle sequences, then random traffic against a transaction model.
module tb_alu_arbiter;

  localparam int NREQ = 4;
  localparam int IW   = 3;

  logic CLK;
  logic RST_N;
  int   n_vec = 0;
  int   n_bad = 0;

  alu_arbiter_if #(.NREQ(NREQ), .IW(IW)) bus ();

  alu_arbiter #(.NREQ(NREQ), .IW(IW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ALU stub: {Y, C, V, N, Z}
  function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    logic [8:0] s;
    logic [7:0] y;
    logic       c;
    logic       v;
    s = '0; y = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; c = s[8];
                  v = (a[7] == b[7]) && (y[7] != a[7]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; y = s[7:0]; c = s[8];
                  v = (a[7] != b[7]) && (y[7] != a[7]); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      default: y = a;
    endcase
    return {y, c, v, y[7], (y == 8'h00)};
  endfunction

  assign {bus.ALU_Y, bus.ALU_C, bus.ALU_V, bus.ALU_N, bus.ALU_Z} =
    alu_fn(bus.ALU_A, bus.ALU_B, bus.ALU_OP);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    int cnt;
    r = -1; cnt = 0;
    for (int k = 0; k < NREQ; k++) if (v[k]) begin r = k; cnt++; end
    if (cnt != 1) r = -1;
    return r;
  endfunction

  task automatic scramble_lanes();
    logic [31:0] rnd;
    rnd = $urandom; bus.REQ_A = rnd[8*NREQ-1:0];
    rnd = $urandom; bus.REQ_B = rnd[8*NREQ-1:0];
    rnd = $urandom; bus.REQ_OP = rnd[3*NREQ-1:0];
  endtask

  task automatic set_lane(input int r, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op);
    bus.REQ_A[8*r +: 8] = a;
    bus.REQ_B[8*r +: 8] = b;
    bus.REQ_OP[3*r +: 3] = op;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.REQ_READY), 0);
    chk({tag, "_rsp_valid"}, 32'(bus.RSP_VALID), 0);
    chk({tag, "_busy"},      32'(bus.BUSY), 0);
    chk({tag, "_grant_idx"}, 32'(bus.GRANT_IDX), 0);
    chk({tag, "_rsp_y"},     32'(bus.RSP_Y), 0);
    chk({tag, "_rsp_flags"}, 32'(bus.RSP_FLAGS), 0);
    chk({tag, "_alu_ops"},   32'({bus.ALU_A, bus.ALU_B, bus.ALU_OP}), 0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    bus.REQ_VALID = '0;
    bus.RSP_READY = '0;
    scramble_lanes();
    step();
    step();
    @(negedge CLK);
    check_reset_vals("reset");
    step();
    RST_N = 1'b1;
  endtask

  // Release all requests and wait (bounded) for the arbiter to go idle.
  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    bus.REQ_VALID = '0;
    bus.RSP_READY = '1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge CLK);
      if (!bus.BUSY) done = 1'b1;
      step();
    end
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL %s_drain: BUSY still 1 after 20 cycles, required 0", tag);
    end
  endtask

  task automatic run_single(input int r, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] op, input logic [7:0] ey, input logic [3:0] ef);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    scramble_lanes();
    set_lane(r, a, b, op);
    bus.REQ_VALID = oh;
    bus.RSP_READY = '1;
    @(negedge CLK);
    chk("single_req_ready", 32'(bus.REQ_READY), 32'(oh));
    chk("single_busy_idle", 32'(bus.BUSY), 0);
    step();
    bus.REQ_VALID = '0;
    @(negedge CLK);
    chk("single_exec_ready", 32'(bus.REQ_READY), 0);
    chk("single_exec_busy", 32'(bus.BUSY), 1);
    chk("single_exec_rspv", 32'(bus.RSP_VALID), 0);
    chk("single_grant_idx", 32'(bus.GRANT_IDX), 32'(r));
    chk("single_alu_in", 32'({bus.ALU_A, bus.ALU_B, bus.ALU_OP}), 32'({a, b, op}));
    step();
    @(negedge CLK);
    chk("single_rsp_valid", 32'(bus.RSP_VALID), 32'(oh));
    chk("single_rsp_y", 32'(bus.RSP_Y), 32'(ey));
    chk("single_rsp_flags", 32'(bus.RSP_FLAGS), 32'(ef));
    chk("single_resp_busy", 32'(bus.BUSY), 1);
    step();
    @(negedge CLK);
    chk("single_done_busy", 32'(bus.BUSY), 0);
    chk("single_done_rspv", 32'(bus.RSP_VALID), 0);
    $display("single req=%0d a=%02h b=%02h op=%0d -> y=%02h flags=%04b",
             r, a, b, op, bus.RSP_Y, bus.RSP_FLAGS);
    step();
  endtask

  int g_idx [8];
  int g_cyc [8];
  int g_cnt;

  task automatic collect_grants(input int n, input int budget);
    g_cnt = 0;
    for (int k = 0; k < 8; k++) begin g_idx[k] = -1; g_cyc[k] = -1; end
    for (int c = 0; c < budget && g_cnt < n; c++) begin
      @(negedge CLK);
      if (bus.REQ_READY != '0) begin
        g_idx[g_cnt] = oh_idx(bus.REQ_READY);
        g_cyc[g_cnt] = c;
        g_cnt++;
      end
      step();
    end
    if (g_cnt < n) begin
      n_vec++; n_bad++;
      $display("FAIL grant_timeout: got %0d grants, required %0d", g_cnt, n);
    end
  endtask

  typedef struct {
    int         req;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] y;
    logic [3:0] f;
  } vec_t;

  vec_t tbl [9];

  // Random-phase transaction model state
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] waiting;
  logic [7:0]      ra  [NREQ];
  logic [7:0]      rb  [NREQ];
  logic [2:0]      rop [NREQ];

  initial begin
    int exp_rr [5];
    int exp_wr [4];
    int mptr;
    bit infl;
    int win;
    int acc_cyc;
    int exp_w;
    logic [11:0] exp_r;
    logic [31:0] rnd;

    tbl[0] = '{2, 8'h7F, 8'h01, 3'd0, 8'h80, 4'b0110};
    tbl[1] = '{0, 8'h01, 8'hFF, 3'd0, 8'h00, 4'b1001};
    tbl[2] = '{1, 8'h10, 8'h20, 3'd1, 8'hF0, 4'b1010};
    tbl[3] = '{3, 8'hF0, 8'h3C, 3'd2, 8'h30, 4'b0000};
    tbl[4] = '{2, 8'h80, 8'h80, 3'd0, 8'h00, 4'b1101};
    tbl[5] = '{1, 8'h55, 8'h55, 3'd4, 8'h00, 4'b0001};
    tbl[6] = '{0, 8'h80, 8'h01, 3'd1, 8'h7F, 4'b0100};
    tbl[7] = '{3, 8'h12, 8'h34, 3'd7, 8'h12, 4'b0000};
    tbl[8] = '{1, 8'hA0, 8'h05, 3'd3, 8'hA5, 4'b0010};
    exp_rr = '{0, 1, 2, 3, 0};
    exp_wr = '{3, 1, 3, 1};

    RST_N = 1'b0;
    do_reset();

    // Directed single operations
    for (int i = 0; i < 9; i++)
      run_single(tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].y, tbl[i].f);

    // Round-robin with everyone requesting and responses always taken
    do_reset();
    scramble_lanes();
    bus.REQ_VALID = '1;
    bus.RSP_READY = '1;
    collect_grants(5, 40);
    for (int k = 0; k < 5; k++) chk("rr_order", 32'(g_idx[k]), 32'(exp_rr[k]));
    for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 3);
    drain("rr");

    // Backpressure on requester 1 (pointer is now 1)
    set_lane(1, 8'h33, 8'h44, 3'd0);
    bus.REQ_VALID = 4'b0010;
    bus.RSP_READY = '0;
    @(negedge CLK);
    chk("bp_accept", 32'(bus.REQ_READY), 32'h2);
    step();
    set_lane(0, 8'h01, 8'h02, 3'd0);
    set_lane(3, 8'h03, 8'h04, 3'd0);
    bus.REQ_VALID = 4'b1001;
    bus.RSP_READY = 4'b1101;
    @(negedge CLK);
    chk("bp_exec_ready", 32'(bus.REQ_READY), 0);
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("bp_rsp_valid", 32'(bus.RSP_VALID), 32'h2);
      chk("bp_rsp_y", 32'(bus.RSP_Y), 32'h77);
      chk("bp_rsp_flags", 32'(bus.RSP_FLAGS), 0);
      chk("bp_stall_ready", 32'(bus.REQ_READY), 0);
      step();
    end
    bus.RSP_READY = '1;
    @(negedge CLK);
    chk("bp_release_valid", 32'(bus.RSP_VALID), 32'h2);
    step();
    @(negedge CLK);
    chk("bp_idle_busy", 32'(bus.BUSY), 0);
    chk("bp_idle_rspv", 32'(bus.RSP_VALID), 0);
    chk("bp_next_grant", 32'(bus.REQ_READY), 32'h8);
    step();
    drain("bp");

    // Wrap and fairness: move pointer to 3, then only 1 and 3 request
    run_single(2, 8'h05, 8'h03, 3'd0, 8'h08, 4'b0000);
    scramble_lanes();
    bus.REQ_VALID = 4'b1010;
    bus.RSP_READY = '1;
    collect_grants(4, 40);
    for (int k = 0; k < 4; k++) chk("wrap_order", 32'(g_idx[k]), 32'(exp_wr[k]));
    drain("wrap");

    // Reset during EXEC aborts the operation
    set_lane(3, 8'h11, 8'h22, 3'd0);
    bus.REQ_VALID = 4'b1000;
    bus.RSP_READY = '1;
    @(negedge CLK);
    chk("mid_accept", 32'(bus.REQ_READY), 32'h8);
    step();
    bus.REQ_VALID = '0;
    @(negedge CLK);
    chk("mid_exec_busy", 32'(bus.BUSY), 1);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    @(negedge CLK);
    check_reset_vals("midrst");
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge CLK);
      chk("midrst_no_rsp", 32'(bus.RSP_VALID), 0);
    end
    step();
    bus.REQ_VALID = 4'b0110;
    @(negedge CLK);
    chk("midrst_first_grant", 32'(bus.REQ_READY), 32'h2);
    step();
    drain("midrst");

    // Random traffic against a transaction-level model
    do_reset();
    pend = '0;
    waiting = '0;
    for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; rop[i] = '0; end
    mptr = 0;
    infl = 1'b0;
    win = 0;
    acc_cyc = 0;
    exp_r = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && !waiting[i] && ($urandom_range(0, 3) == 0)) begin
          pend[i] = 1'b1;
          rnd = $urandom;
          ra[i] = rnd[7:0];
          rb[i] = rnd[15:8];
          rop[i] = rnd[18:16];
        end
        bus.REQ_A[8*i +: 8] = ra[i];
        bus.REQ_B[8*i +: 8] = rb[i];
        bus.REQ_OP[3*i +: 3] = rop[i];
      end
      bus.REQ_VALID = pend;
      rnd = $urandom;
      bus.RSP_READY = rnd[NREQ-1:0];
      @(negedge CLK);
      if (!infl) begin
        chk("rnd_idle_rspv", 32'(bus.RSP_VALID), 0);
        exp_w = -1;
        for (int k = 0; k < NREQ; k++)
          if (exp_w < 0 && pend[(mptr + k) % NREQ]) exp_w = (mptr + k) % NREQ;
        if (exp_w < 0) begin
          chk("rnd_no_grant", 32'(bus.REQ_READY), 0);
        end else begin
          chk("rnd_grant", 32'(bus.REQ_READY), 32'(1 << exp_w));
          win = exp_w;
          infl = 1'b1;
          acc_cyc = cyc;
          exp_r = alu_fn(ra[win], rb[win], rop[win]);
          pend[win] = 1'b0;
          waiting[win] = 1'b1;
        end
      end else begin
        chk("rnd_busy_ready", 32'(bus.REQ_READY), 0);
        if (cyc == acc_cyc + 1) begin
          chk("rnd_exec_rspv", 32'(bus.RSP_VALID), 0);
        end else begin
          chk("rnd_rsp_valid", 32'(bus.RSP_VALID), 32'(1 << win));
          chk("rnd_rsp_data", 32'({bus.RSP_Y, bus.RSP_FLAGS}), 32'(exp_r));
          chk("rnd_grant_idx", 32'(bus.GRANT_IDX), 32'(win));
          if (bus.RSP_READY[win]) begin
            infl = 1'b0;
            waiting[win] = 1'b0;
            mptr = (win + 1) % NREQ;
          end
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU (A, B, OP in; Y, C, V, N, Z out) among NREQ requesters in the minesweeper game logic, e.g. the neighbour-count unit, score counter and cursor logic.
- Arbitrates round-robin, latches the winner's operands, drives the ALU for one cycle and registers Y and the flags.
- Returns the registered result to the winning requester over a valid/ready handshake.
- The ALU is instantiated beside this block, not inside it. OP is treated as an opaque 3-bit code.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IW, 3, width of the grant index; must be at least clog2(NREQ).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- REQ_VALID  in  NREQ  per-requester request valid.
- REQ_A  in  8*NREQ  operand A, packed; requester i uses bits [8i+7:8i].
- REQ_B  in  8*NREQ  operand B, packed the same way.
- REQ_OP  in  3*NREQ  ALU opcode, packed; requester i uses bits [3i+2:3i].
- REQ_READY  out  NREQ  one-hot accept strobe.
- RSP_VALID  out  NREQ  one-hot response valid.
- RSP_READY  in  NREQ  per-requester response ready.
- RSP_Y  out  8  registered ALU result.
- RSP_FLAGS  out  4  registered flags {C,V,N,Z}.
- ALU_A  out  8  to the ALU A input.
- ALU_B  out  8  to the ALU B input.
- ALU_OP  out  3  to the ALU OP input.
- ALU_Y  in  8  from the ALU.
- ALU_C, ALU_V, ALU_N, ALU_Z  in  1 each  ALU flags.
- BUSY  out  1  high whenever the state is not IDLE.
- GRANT_IDX  out  IW  index of the current or last granted requester.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous, active-low (RST_N sampled on the rising CLK edge).
- Reset values:
  - state = IDLE, priority pointer = 0, GRANT_IDX = 0.
  - Operand registers = 0, RSP_Y = 0, RSP_FLAGS = 0.
  - REQ_READY = 0, RSP_VALID = 0, BUSY = 0.
  - ALU_A/ALU_B/ALU_OP = 0.
- Reset asserted in any state aborts the operation in flight. No response is ever issued for the aborted request.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first index with REQ_VALID set, searching upward from the priority pointer and wrapping at NREQ-1 to 0.
  - REQ_READY[winner] = 1, driven combinationally, in that same cycle only. At most one bit of REQ_READY is ever set.
  - On that edge: latch REQ_A/B/OP[winner], set GRANT_IDX = winner, go to EXEC.
  - No valid requests: stay in IDLE, REQ_READY = 0.
- EXEC:
  - ALU_A/ALU_B/ALU_OP = latched operands. These hold the latched values in every state.
  - At the end of EXEC: RSP_Y <= ALU_Y, RSP_FLAGS <= {ALU_C,ALU_V,ALU_N,ALU_Z}, go to RESP.
- RESP:
  - RSP_VALID[GRANT_IDX] = 1 (registered, one-hot). RSP_Y and RSP_FLAGS are stable for the whole of RESP.
  - When RSP_READY[GRANT_IDX] = 1: go to IDLE, priority pointer <= GRANT_IDX+1 mod NREQ.
  - RSP_READY bits of other requesters are ignored.
  - Otherwise hold indefinitely; there is no timeout.
- Latency:
  - Accept at edge t, RSP_VALID high in cycle t+2.
  - If RSP_READY is already high, the next accept happens in cycle t+3. Peak throughput is one operation per 3 cycles.
- Requester rules:
  - A requester holds REQ_VALID and its operands until it sees REQ_READY.
  - It must not issue a new request before its response has been consumed. The arbiter does not check this rule.
- REQ_VALID changes in EXEC or RESP have no effect.
- Fairness: a continuously requesting requester is granted within NREQ grants.
- The ALU is combinational; this block adds no bypass. The ALU output is sampled only in EXEC.

Test Plan:
- Single op: ALU stub computes Y = A+B with flags. Requester 2 drives A=8'h7F, B=8'h01, OP=3'b000. Required: REQ_READY=4'b0100 for one cycle; RSP_VALID=4'b0100 two cycles later; RSP_Y=8'h80; RSP_FLAGS={C0,V1,N1,Z0}; BUSY high for 2 cycles.
- Round-robin: all 4 REQ_VALID held high and RSP_READY tied high. Required grant order after reset: 0,1,2,3,0. Accepts exactly 3 cycles apart.
- Backpressure: requester 1 response with RSP_READY[1] low for 5 cycles. Required: RSP_VALID[1], RSP_Y and RSP_FLAGS held stable; no REQ_READY during the stall; return to IDLE the cycle after RSP_READY[1]=1.
- Wrap and fairness: pointer at 3 with only requesters 1 and 3 valid. Required: grants 3,1,3,1; never two consecutive grants to 1.
- Reset mid-op: RST_N low during EXEC for one edge. Required: all outputs at reset values next cycle; no RSP_VALID for the aborted request; first grant after reset goes to the lowest valid index.
- Zero result: A=8'h01, B=8'hFF into the add stub. Required: RSP_Y=8'h00, Z=1, C=1.
